cpu_div_cell: RTL

Multi-cycle integer divide unit for the CPU execute stage, providing the inverse operation of the pipelined multiplier cell. It accepts a dividend/divisor pair with a one-cycle start strobe and runs a radix-2 restoring division, one quotient bit per clock. It returns quotient and remainder with a done pulse. Signed and unsigned division are supported; the stall logic uses `busy` to hold the pipeline while the unit iterates.

---
 rtl/cpu_div_cell.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/cpu_div_cell.sv
// cpu_div_cell
//   Multi-cycle radix-2 restoring divider for the execute stage. One quotient
//   bit per clock; signed operands are reduced to magnitudes up front and the
//   signs are re-applied in a single fix-up cycle. Latency is WIDTH+2 cycles
//   from the start edge, for every operand including a zero divisor.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-high
//   E_div_start  request strobe, accepted only while not busy
//   E_div_signed 1 = two's-complement operands, 0 = unsigned
//   E_src1       dividend
//   E_src2       divisor
//   busy         high while a division is iterating or being fixed up
//   done         one-cycle pulse; results valid in this cycle
//   div_quot     quotient (held between done pulses)
//   div_rem      remainder (held between done pulses)
//   div_by_zero  divisor was zero (held between done pulses)
module cpu_div_cell #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             E_div_start,
  input  logic             E_div_signed,
  input  logic [WIDTH-1:0] E_src1,
  input  logic [WIDTH-1:0] E_src2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] div_quot,
  output logic [WIDTH-1:0] div_rem,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           state, state_next;
  logic             accept;

  // Iteration state. The remainder register only needs WIDTH bits: after each
  // restore step it is strictly less than the divisor. The WIDTH+1-bit value
  // exists only transiently as the shifted remainder used in the compare.
  logic [WIDTH-1:0] rem_acc;
  logic [WIDTH-1:0] quo_sr;
  logic [WIDTH-1:0] dvsr;
  logic [WIDTH-1:0] src1_raw;
  logic [CW-1:0]    step_cnt;
  logic             neg_q;
  logic             neg_r;
  logic             dz_flag;

  // Combinational datapath.
  logic             sign1, sign2;
  logic [WIDTH-1:0] mag1, mag2;
  logic [WIDTH:0]   rem_shift;
  logic             rem_ge;
  logic [WIDTH-1:0] rem_sub;
  logic [WIDTH-1:0] quot_fix, rem_fix;

  always_comb begin
    sign1     = E_div_signed & E_src1[WIDTH-1];
    sign2     = E_div_signed & E_src2[WIDTH-1];
    mag1      = sign1 ? -E_src1 : E_src1;
    mag2      = sign2 ? -E_src2 : E_src2;
    rem_shift = {rem_acc, quo_sr[WIDTH-1]};
    rem_ge    = rem_shift >= {1'b0, dvsr};
    // Only taken when rem_shift >= dvsr, so the difference fits in WIDTH bits.
    rem_sub   = rem_shift[WIDTH-1:0] - dvsr;
    quot_fix  = neg_q ? -quo_sr : quo_sr;
    rem_fix   = neg_r ? -rem_acc : rem_acc;
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state and control outputs.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave a variable unassigned and infer a latch.
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (E_div_start) begin
          accept     = 1'b1;
          state_next = CALC;
        end
      end
      CALC: begin
        busy = 1'b1;
        if (step_cnt == CW'(1)) state_next = FIX;
      end
      FIX: begin
        busy       = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (E_div_start) begin
          accept     = 1'b1;
          state_next = CALC;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      rem_acc     <= '0;
      quo_sr      <= '0;
      dvsr        <= '0;
      src1_raw    <= '0;
      step_cnt    <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      dz_flag     <= 1'b0;
      div_quot    <= '0;
      div_rem     <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      rem_acc  <= '0;
      quo_sr   <= mag1;
      dvsr     <= mag2;
      src1_raw <= E_src1;
      step_cnt <= CW'(WIDTH);
      neg_q    <= sign1 ^ sign2;
      neg_r    <= sign1;
      dz_flag  <= (E_src2 == '0);
    end else if (state == CALC) begin
      rem_acc  <= rem_ge ? rem_sub : rem_shift[WIDTH-1:0];
      quo_sr   <= {quo_sr[WIDTH-2:0], rem_ge};
      step_cnt <= step_cnt - CW'(1);
    end else if (state == FIX) begin
      // A zero divisor bypasses sign fixing and returns the raw dividend.
      if (dz_flag) begin
        div_quot    <= '1;
        div_rem     <= src1_raw;
        div_by_zero <= 1'b1;
      end else begin
        div_quot    <= quot_fix;
        div_rem     <= rem_fix;
        div_by_zero <= 1'b0;
      end
    end
  end

endmodule
